rv32i_wb_fetch: RTL and testbench
=================================

RV32I_WB_FETCH -- requirements
Module: rv32i_wb_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset (bits [1:0] ignored).
REQ-002 SHALL have parameter MAX_WAIT_CYCLES, default 0 (0 = no timeout), the ack-timeout limit in cycles.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-004 Fetch-control ports SHALL be: redirect_valid_i in 1 load new PC; redirect_pc_i in 32 target PC.
REQ-005 Instruction-output ports SHALL be: instr_valid_o out 1; instr_ready_i in 1; instr_o out 32; instr_pc_o out 32; instr_err_o out 1 (bus error or timeout).
REQ-006 Wishbone initiator ports SHALL be: wb_cyc_o out 1; wb_stb_o out 1; wb_we_o out 1; wb_sel_o out WB_SEL_WIDTH; wb_adr_o out WB_ADDR_WIDTH; wb_dat_o out WB_DATA_WIDTH; wb_dat_i in WB_DATA_WIDTH; wb_ack_i in 1; wb_err_i in 1; wb_stall_i in 1.

Function
REQ-007 wb_we_o SHALL be 0, wb_sel_o SHALL be all-ones and wb_dat_o SHALL be 0 at all times.
REQ-008 SHALL hold at most one outstanding bus cycle (classic handshake): wb_cyc_o=wb_stb_o=1 with stable wb_adr_o from issue through the ack/err cycle inclusive, deasserted the following cycle.
REQ-009 wb_stb_o SHALL be low for at least one cycle between consecutive bus cycles.
REQ-010 wb_stall_i SHALL only extend the request; the address SHALL remain stable while stalled.
REQ-011 The FSM SHALL have states: S_IDLE (no bus cycle), S_BUS (cycle active, response kept), S_DRAIN (cycle active, response discarded), S_HALT (stopped after error).
REQ-012 S_IDLE->S_BUS SHALL occur when the output slot is empty, or is consumed this cycle (instr_valid_o & instr_ready_i), and no redirect is pending.
REQ-013 On ack in S_BUS: instr_o<=wb_dat_i, instr_pc_o<=fetch PC, instr_err_o<=0, instr_valid_o<=1, PC<=PC+4 with 32-bit wrap (32'hFFFF_FFFC -> 0), next state S_IDLE.
REQ-014 On wb_err_i in S_BUS, or timeout, the block SHALL present instr_err_o=1, instr_o=0 and instr_pc_o=fetch PC, then enter S_HALT.
REQ-015 The timeout counter SHALL count cycles in S_BUS; when it reaches MAX_WAIT_CYCLES it SHALL raise the error, and it SHALL clear on every issue.
REQ-016 instr_o, instr_pc_o and instr_err_o SHALL remain stable while instr_valid_o=1 and instr_ready_i=0.
REQ-017 Minimum throughput SHALL be one instruction per 3 cycles with a zero-wait slave (issue, ack, gap).
REQ-018 On redirect, PC<={redirect_pc_i[31:2],2'b00}, instr_valid_o SHALL clear next cycle, and the redirect SHALL win over a simultaneous ready.
REQ-019 A redirect in S_BUS SHALL go to S_DRAIN; a redirect in S_DRAIN SHALL only update the PC.
REQ-020 S_DRAIN SHALL keep the cycle until ack/err, discard the response, and return to S_IDLE.
REQ-021 A redirect coinciding with ack/err SHALL discard that response.
REQ-022 S_HALT SHALL issue no bus cycles; only a redirect SHALL leave it (to S_IDLE).
REQ-023 wb_ack_i or wb_err_i while wb_cyc_o=0 SHALL be ignored.

Reset
REQ-024 On rst_ni low, the block SHALL enter S_IDLE with PC=RESET_PC, timeout counter=0, and all outputs 0 (wb_sel_o all-ones).
REQ-025 A reset mid-cycle SHALL drop wb_cyc_o and wb_stb_o immediately (asynchronously).
REQ-026 The first issue SHALL occur in the first clock after reset release.

Structure
REQ-027 WB_*_WIDTH SHALL come from rv32i_wb_pkg, and the FSM state enum type SHALL be added to rv32i_wb_pkg.
REQ-028 The block SHALL be one module with no sub-modules; the output slot SHALL be a single register stage inside the module.
REQ-029 SVA SHALL check: stb implies cyc; wb_adr_o stable while stb & !ack & !err; wb_adr_o[1:0]==0; we=0; instr_valid_o and its payload stable until ready.

Verification
REQ-030 Reset with RESET_PC=0x100 against a zero-wait memory containing 0x13 at every word, ready held high -> instr_pc_o sequence 0x100, 0x104, 0x108, all with instr_o=0x13.
REQ-031 Slave with 3 stall cycles plus 2 wait cycles -> wb_adr_o constant over the cycle and exactly one instruction delivered.
REQ-032 Redirect to 0x203 during an outstanding fetch of 0x10 -> 0x10 response dropped, next bus cycle to 0x200, next instr_pc_o=0x200.
REQ-033 wb_err_i on fetch 0x40 -> instr_err_o=1 with instr_pc_o=0x40, no further wb_cyc_o until redirect to 0x0, then fetch at 0x0.
REQ-034 instr_ready_i held low for 10 cycles -> exactly one bus cycle issued and output payload stable throughout.
REQ-035 Redirect to 0xFFFF_FFFC -> fetches at 0xFFFF_FFFC then 0x0000_0000; separately, MAX_WAIT_CYCLES=4 with no ack -> error after 4 cycles.

Source files
------------

// File: rtl/rv32i_wb_pkg.sv
// Shared Wishbone widths and fetch-unit types for the RV32I front end.
package rv32i_wb_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 32;
  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_wb_fetch_sva.sv
// Protocol and output-slot properties for rv32i_wb_fetch, attached alongside it.
module rv32i_wb_fetch_sva
  import rv32i_wb_pkg::*;
(
  input logic                     clk_i,
  input logic                     rst_ni,
  input logic                     wb_cyc_o,
  input logic                     wb_stb_o,
  input logic                     wb_we_o,
  input logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
  input logic                     wb_ack_i,
  input logic                     wb_err_i,
  input logic                     redirect_valid_i,
  input logic                     instr_valid_o,
  input logic                     instr_ready_i,
  input logic [31:0]              instr_o,
  input logic [31:0]              instr_pc_o,
  input logic                     instr_err_o
);

  a_stb_cyc: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wb_stb_o |-> wb_cyc_o);

  a_adr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wb_stb_o && !wb_ack_i && !wb_err_i) |=> $stable(wb_adr_o));

  a_adr_align: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wb_adr_o[1:0] == 2'b00);

  a_we_low: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !wb_we_o);

  // A redirect is the only thing allowed to withdraw an unconsumed instruction.
  a_slot_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_valid_o && !instr_ready_i && !redirect_valid_i) |=>
      (instr_valid_o && $stable(instr_o) && $stable(instr_pc_o) && $stable(instr_err_o)));

endmodule

// File: rtl/rv32i_wb_fetch.sv
// Instruction fetch unit: one classic Wishbone read at a time into a
// single-entry output slot, with redirect, error halt and optional ack timeout.
module rv32i_wb_fetch
  import rv32i_wb_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_WAIT_CYCLES = 32'd0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     redirect_valid_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  output logic                     instr_err_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_stall_i
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, adr_r, cnt_r, instr_r, ipc_r;
  logic         cyc_r, valid_r, err_r;
  logic         slot_free_s, resp_s, timeout_s;
  logic         issue_s, deliver_s, fault_s;
  logic         stall_unused_s;

  // Stall only stretches a classic cycle; the held address already covers it.
  assign stall_unused_s = wb_stall_i;

  assign slot_free_s = !valid_r || instr_ready_i;
  assign resp_s      = wb_ack_i || wb_err_i;
  assign timeout_s   = (MAX_WAIT_CYCLES != 32'd0) && (state_r == S_BUS) &&
                       (cnt_r == MAX_WAIT_CYCLES - 32'd1);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= S_IDLE;
    else         state_r <= state_s;
  end

  // Next-state logic; a redirect always wins over a response or a ready.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!redirect_valid_i && slot_free_s) state_s = S_BUS;
        else                                  state_s = S_IDLE;
      end
      S_BUS: begin
        if (redirect_valid_i)                     state_s = resp_s ? S_IDLE : S_DRAIN;
        else if (wb_err_i)                        state_s = S_HALT;
        else if (wb_ack_i)                        state_s = S_IDLE;
        else if (timeout_s)                       state_s = S_HALT;
        else                                      state_s = S_BUS;
      end
      S_DRAIN: begin
        if (resp_s) state_s = S_IDLE;
        else        state_s = S_DRAIN;
      end
      S_HALT: begin
        if (redirect_valid_i) state_s = S_IDLE;
        else                  state_s = S_HALT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Per-cycle actions decoded from the current and next state.
  always_comb begin
    issue_s   = 1'b0;
    deliver_s = 1'b0;
    fault_s   = 1'b0;
    if (state_r == S_IDLE && state_s == S_BUS) issue_s = 1'b1;
    else                                       issue_s = 1'b0;
    if (state_r == S_BUS && !redirect_valid_i) begin
      if (wb_err_i)      fault_s   = 1'b1;
      else if (wb_ack_i) deliver_s = 1'b1;
      else if (timeout_s) fault_s  = 1'b1;
      else               deliver_s = 1'b0;
    end else begin
      fault_s = 1'b0;
    end
  end

  // Bus request, PC and timeout counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_r <= 1'b0;
      adr_r <= 32'h0000_0000;
      cnt_r <= 32'h0000_0000;
      pc_r  <= word_align(RESET_PC);
    end else begin
      cyc_r <= (state_s == S_BUS) || (state_s == S_DRAIN);
      if (issue_s) begin
        adr_r <= pc_r;
        cnt_r <= 32'h0000_0000;
      end else if (state_r == S_BUS) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (redirect_valid_i) pc_r <= word_align(redirect_pc_i);
      else if (deliver_s)   pc_r <= pc_r + 32'd4;
      else                  pc_r <= pc_r;
    end
  end

  // Output slot: filled only from S_BUS, which is entered with the slot empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      instr_r <= 32'h0000_0000;
      ipc_r   <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else if (redirect_valid_i) begin
      valid_r <= 1'b0;
    end else if (deliver_s) begin
      valid_r <= 1'b1;
      instr_r <= wb_dat_i;
      ipc_r   <= adr_r;
      err_r   <= 1'b0;
    end else if (fault_s) begin
      valid_r <= 1'b1;
      instr_r <= 32'h0000_0000;
      ipc_r   <= adr_r;
      err_r   <= 1'b1;
    end else if (valid_r && instr_ready_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign wb_cyc_o      = cyc_r;
  assign wb_stb_o      = cyc_r;
  assign wb_we_o       = 1'b0;
  assign wb_sel_o      = {WB_SEL_WIDTH{1'b1}};
  assign wb_adr_o      = adr_r;
  assign wb_dat_o      = {WB_DATA_WIDTH{1'b0}};
  assign instr_valid_o = valid_r;
  assign instr_o       = instr_r;
  assign instr_pc_o    = ipc_r;
  assign instr_err_o   = err_r;

endmodule

// File: tb/tb_rv32i_wb_fetch.sv
// Directed bench for rv32i_wb_fetch with a cycle-stepped Wishbone slave model.
module tb_rv32i_wb_fetch;

  logic        clk, rst_n;
  logic        redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_err;
  logic [31:0] instr, instr_pc;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;

  // second instance: timeout build, slave never answers
  logic        d2_valid, d2_err, d2_cyc, d2_stb, d2_we;
  logic [31:0] d2_instr, d2_pc, d2_adr, d2_dat_o;
  logic [3:0]  d2_sel;
  logic        d2_zero;
  logic        d2_ready;
  logic [31:0] d2_zero32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        err;
  } rec_t;
  rec_t q[$];

  int checks = 0;
  int errors = 0;
  int cfg_stall = 0, cfg_wait = 0;
  bit err_en = 1'b0;
  logic [31:0] err_adr = 32'h0;
  bit act = 1'b0;
  int st_left = 0, wt_left = 0;
  logic [31:0] act_adr = 32'h0;
  int bus_cycles = 0, cyc_hi = 0;

  rv32i_wb_fetch #(.RESET_PC(32'h0000_0100), .MAX_WAIT_CYCLES(0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .instr_err_o(instr_err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_stall_i(wb_stall));

  rv32i_wb_fetch_sva chk_dut (
    .clk_i(clk), .rst_ni(rst_n), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_we_o(wb_we), .wb_adr_o(wb_adr), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .redirect_valid_i(redirect_valid), .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_err_o(instr_err));

  rv32i_wb_fetch #(.RESET_PC(32'h0000_0500), .MAX_WAIT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_ni(rst_n),
    .redirect_valid_i(d2_zero), .redirect_pc_i(d2_zero32),
    .instr_valid_o(d2_valid), .instr_ready_i(d2_ready),
    .instr_o(d2_instr), .instr_pc_o(d2_pc), .instr_err_o(d2_err),
    .wb_cyc_o(d2_cyc), .wb_stb_o(d2_stb), .wb_we_o(d2_we), .wb_sel_o(d2_sel),
    .wb_adr_o(d2_adr), .wb_dat_o(d2_dat_o), .wb_dat_i(d2_zero32),
    .wb_ack_i(d2_zero), .wb_err_i(d2_zero), .wb_stall_i(d2_zero));

  rv32i_wb_fetch_sva chk_to (
    .clk_i(clk), .rst_ni(rst_n), .wb_cyc_o(d2_cyc), .wb_stb_o(d2_stb),
    .wb_we_o(d2_we), .wb_adr_o(d2_adr), .wb_ack_i(d2_zero), .wb_err_i(d2_zero),
    .redirect_valid_i(d2_zero), .instr_valid_o(d2_valid),
    .instr_ready_i(d2_ready), .instr_o(d2_instr), .instr_pc_o(d2_pc),
    .instr_err_o(d2_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the slave response for the current cycle, log handshakes, advance one clock.
  task automatic step();
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_i = 32'h0;
    if (wb_cyc) cyc_hi++;
    if (wb_cyc && wb_stb) begin
      if (!act) begin
        act = 1'b1; act_adr = wb_adr; st_left = cfg_stall; wt_left = cfg_wait;
        bus_cycles++;
      end else begin
        chk("adr_stable", wb_adr, act_adr);
      end
      if (st_left > 0) begin
        wb_stall = 1'b1; st_left--;
      end else if (wt_left > 0) begin
        wt_left--;
      end else begin
        if (err_en && act_adr == err_adr) wb_err = 1'b1;
        else begin wb_ack = 1'b1; wb_dat_i = 32'h0000_0013; end
        act = 1'b0;
      end
    end else begin
      act = 1'b0;
    end
    if (instr_valid && instr_ready && !redirect_valid)
      q.push_back('{pc: instr_pc, ins: instr, err: instr_err});
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
    q.delete();
  endtask

  task automatic wait_issue(input logic [31:0] exp_adr, input string tag);
    int n0 = bus_cycles;
    int n = 0;
    while (bus_cycles == n0 && n < 40) begin step(); n++; end
    chk({tag, "_seen"}, 32'(bus_cycles != n0), 32'd1);
    chk(tag, act_adr, exp_adr);
  endtask

  task automatic wait_deliver(input logic [31:0] pc, input logic [31:0] ins,
                              input logic err, input string tag);
    rec_t r;
    int n = 0;
    while (q.size() == 0 && n < 40) begin step(); n++; end
    chk({tag, "_seen"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      r = q.pop_front();
      chk({tag, "_pc"}, r.pc, pc);
      chk({tag, "_ins"}, r.ins, ins);
      chk({tag, "_err"}, 32'(r.err), 32'(err));
    end else begin
      chk({tag, "_empty"}, 32'(q.size()), 32'd1);
    end
  endtask

  initial begin
    int b0;
    int n;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_i = 32'h0;
    d2_zero = 1'b0; d2_zero32 = 32'h0; d2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_adr", wb_adr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_sel", 32'(wb_sel), 32'h0000_000F);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_dat", wb_dat_o, 32'h0);

    // Reset sequence with zero-wait memory; timeout instance runs in parallel.
    rst_n = 1'b1;
    step();
    chk("first_issue_cyc", 32'(wb_cyc), 32'd1);
    chk("first_issue_adr", wb_adr, 32'h0000_0100);
    chk("to_issue_adr", d2_adr, 32'h0000_0500);
    step(); step(); step();
    chk("to_still_waiting", 32'(d2_cyc), 32'd1);
    chk("to_no_valid_yet", 32'(d2_valid), 32'd0);
    step();
    chk("to_valid", 32'(d2_valid), 32'd1);
    chk("to_err", 32'(d2_err), 32'd1);
    chk("to_pc", d2_pc, 32'h0000_0500);
    chk("to_instr", d2_instr, 32'h0);
    chk("to_cyc_drop", 32'(d2_cyc), 32'd0);
    wait_deliver(32'h0000_0100, 32'h13, 1'b0, "seq0");
    wait_deliver(32'h0000_0104, 32'h13, 1'b0, "seq1");
    wait_deliver(32'h0000_0108, 32'h13, 1'b0, "seq2");

    // Redirect during an outstanding fetch drops its response.
    cfg_wait = 4;
    redirect(32'h0000_0010);
    wait_issue(32'h0000_0010, "rd_issue10");
    redirect(32'h0000_0203);
    wait_issue(32'h0000_0200, "rd_issue200");
    wait_deliver(32'h0000_0200, 32'h13, 1'b0, "rd_deliver");

    // Stalled slave with ready held low: one cycle, stable address and payload.
    instr_ready = 1'b0;
    n = 0;
    while (!(instr_valid && !wb_cyc) && n < 40) begin step(); n++; end
    cfg_stall = 3; cfg_wait = 2;
    redirect(32'h0000_0300);
    b0 = bus_cycles; cyc_hi = 0;
    repeat (15) step();
    chk("stall_one_cycle", 32'(bus_cycles - b0), 32'd1);
    chk("stall_cyc_len", 32'(cyc_hi), 32'd6);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_pc", instr_pc, 32'h0000_0300);
    chk("stall_instr", instr, 32'h13);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_pc", instr_pc, 32'h0000_0300);
      chk("hold_instr", instr, 32'h13);
    end
    chk("hold_no_extra_cycle", 32'(bus_cycles - b0), 32'd1);
    instr_ready = 1'b1;
    wait_deliver(32'h0000_0300, 32'h13, 1'b0, "hold_deliver");

    // Bus error halts fetching until a redirect.
    cfg_stall = 0; cfg_wait = 0; err_en = 1'b1; err_adr = 32'h0000_0040;
    redirect(32'h0000_0040);
    wait_issue(32'h0000_0040, "err_issue");
    wait_deliver(32'h0000_0040, 32'h0, 1'b1, "err_deliver");
    b0 = bus_cycles;
    repeat (10) step();
    chk("halt_no_cycles", 32'(bus_cycles - b0), 32'd0);
    chk("halt_cyc_low", 32'(wb_cyc), 32'd0);
    redirect(32'h0000_0000);
    wait_issue(32'h0000_0000, "halt_exit_issue");
    wait_deliver(32'h0000_0000, 32'h13, 1'b0, "halt_exit_deliver");

    // PC wrap at the top of the address space.
    err_en = 1'b0;
    redirect(32'hFFFF_FFFC);
    wait_issue(32'hFFFF_FFFC, "wrap_issue_top");
    wait_deliver(32'hFFFF_FFFC, 32'h13, 1'b0, "wrap_top");
    wait_issue(32'h0000_0000, "wrap_issue_zero");
    wait_deliver(32'h0000_0000, 32'h13, 1'b0, "wrap_zero");
    chk("to_stays_halted", 32'(d2_cyc), 32'd0);

    // Asynchronous reset in the middle of a bus cycle.
    cfg_wait = 5;
    redirect(32'h0000_0080);
    wait_issue(32'h0000_0080, "arst_issue");
    chk("arst_cyc_before", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(wb_cyc), 32'd0);
    chk("arst_stb", 32'(wb_stb), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
